// File: rtl/md_pkg.sv
// Shared definitions for the RV32M multiply/divide scheduler and its engine.
package md_pkg;

  localparam int MD_DATA_WIDTH = 32;
  localparam int MD_F3_WIDTH   = 3;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int FWD_OPA = 0;
  localparam int FWD_OPB = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN_A = 2'd1,
    ST_RUN_B = 2'd2,
    ST_DONE  = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_engine.sv
// Shared RV32M engine: pipelined multiplier, restoring divider, 1-cycle special cases.
// done_o is a one-cycle pulse exactly L cycles after start_i; result_o is valid only then.
module md_engine
  import md_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH,
  parameter int MUL_LAT    = 2,
  parameter int F3_WIDTH   = MD_F3_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kill_i,
  input  logic                  start_i,
  input  logic [F3_WIDTH-1:0]   f3_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic          is_div, div_signed, is_rem, div_zero, div_ovf, a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag, spec_res;

  assign is_div     = f3_i[2];
  assign div_signed = ~f3_i[0];
  assign is_rem     = f3_i[1];
  assign div_zero   = (b_i == '0);
  assign div_ovf    = div_signed && (a_i == {1'b1, {(W-1){1'b0}}}) && (b_i == '1);
  assign a_neg      = div_signed & a_i[W-1];
  assign b_neg      = div_signed & b_i[W-1];
  assign a_mag      = a_neg ? -a_i : a_i;
  assign b_mag      = b_neg ? -b_i : b_i;
  assign spec_res   = div_zero ? (is_rem ? a_i : '1) : (is_rem ? '0 : a_i);

  logic          spec_q;
  logic [W-1:0]  spec_res_q;
  logic          div_run_q, div_fix_q, neg_q_q, neg_r_q, is_rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]  quo_q, rem_q, dvs_q;
  logic [W:0]    shifted, trial;

  assign shifted = {rem_q, quo_q[W-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      div_run_q  <= 1'b0;
      div_fix_q  <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      is_rem_q   <= 1'b0;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
    end else begin
      spec_q    <= 1'b0;
      div_fix_q <= 1'b0;
      if (kill_i) begin
        div_run_q <= 1'b0;
      end else if (start_i && is_div) begin
        if (div_zero || div_ovf) begin
          spec_q     <= 1'b1;
          spec_res_q <= spec_res;
        end else begin
          div_run_q <= 1'b1;
          cnt_q     <= '0;
          quo_q     <= a_mag;
          rem_q     <= '0;
          dvs_q     <= b_mag;
          neg_q_q   <= a_neg ^ b_neg;
          neg_r_q   <= a_neg;
          is_rem_q  <= is_rem;
        end
      end else if (div_run_q) begin
        // One restoring step per cycle; trial[W] is the borrow.
        if (!trial[W]) begin
          rem_q <= trial[W-1:0];
          quo_q <= {quo_q[W-2:0], 1'b1};
        end else begin
          rem_q <= shifted[W-1:0];
          quo_q <= {quo_q[W-2:0], 1'b0};
        end
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_W'(W-1)) begin
          div_run_q <= 1'b0;
          div_fix_q <= 1'b1;
        end
      end
    end
  end

  logic [W-1:0] q_fix, r_fix, div_res;
  assign q_fix   = neg_q_q ? -quo_q : quo_q;
  assign r_fix   = neg_r_q ? -rem_q : rem_q;
  assign div_res = is_rem_q ? r_fix : q_fix;

  // Operands are widened by one bit so a single signed product covers all four multiplies.
  logic [W:0]       mul_a_q, mul_b_q;
  logic             mul_hi_q;
  logic [2*W+1:0]   prod_full;
  logic             unused_prod_top;
  logic [MUL_LAT-1:0] mul_vld_q;
  logic [2*W-1:0]   mul_p_q [MUL_LAT-1];

  assign prod_full = {{(W+1){mul_a_q[W]}}, mul_a_q} * {{(W+1){mul_b_q[W]}}, mul_b_q};
  assign unused_prod_top = ^prod_full[2*W+1:2*W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_hi_q     <= 1'b0;
      mul_vld_q[0] <= 1'b0;
      mul_p_q[0]   <= '0;
    end else begin
      mul_vld_q[0] <= start_i & ~is_div & ~kill_i;
      mul_p_q[0]   <= prod_full[2*W-1:0];
      if (start_i && !is_div) begin
        mul_a_q  <= {((f3_i == F3_MULH) || (f3_i == F3_MULHSU)) & a_i[W-1], a_i};
        mul_b_q  <= {(f3_i == F3_MULH) & b_i[W-1], b_i};
        mul_hi_q <= (f3_i != F3_MUL);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < MUL_LAT; gi++) begin : g_mul_vld
      always_ff @(posedge clk or posedge rst) begin
        if (rst) mul_vld_q[gi] <= 1'b0;
        else     mul_vld_q[gi] <= mul_vld_q[gi-1] & ~kill_i;
      end
    end
    for (gi = 1; gi < MUL_LAT - 1; gi++) begin : g_mul_pipe
      always_ff @(posedge clk or posedge rst) begin
        if (rst) mul_p_q[gi] <= '0;
        else     mul_p_q[gi] <= mul_p_q[gi-1];
      end
    end
  endgenerate

  logic [W-1:0] mul_out;
  assign mul_out  = mul_hi_q ? mul_p_q[MUL_LAT-2][2*W-1:W] : mul_p_q[MUL_LAT-2][W-1:0];
  assign done_o   = spec_q | div_fix_q | mul_vld_q[MUL_LAT-1];
  assign result_o = spec_q ? spec_res_q : (div_fix_q ? div_res : mul_out);

endmodule

// File: rtl/md_scheduler.sv
// Serialises one M-extension engine across the two EX lanes (A first, then B) and
// stalls the pipeline until the whole bundle is done.
module md_scheduler
  import md_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH,
  parameter int MUL_LAT    = 2,
  parameter int F3_WIDTH   = MD_F3_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_A,
  input  logic [F3_WIDTH-1:0]   f3_A,
  input  logic [DATA_WIDTH-1:0] opa_A,
  input  logic [DATA_WIDTH-1:0] opb_A,
  input  logic                  req_B,
  input  logic [F3_WIDTH-1:0]   f3_B,
  input  logic [DATA_WIDTH-1:0] opa_B,
  input  logic [DATA_WIDTH-1:0] opb_B,
  input  logic [1:0]            fwd_B,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result_A,
  output logic [DATA_WIDTH-1:0] result_B,
  output logic                  busy
);

  md_state_e                state_q, state_d;
  logic                     req_b_q;
  logic [F3_WIDTH-1:0]      f3_b_q;
  logic [DATA_WIDTH-1:0]    opa_b_q, opb_b_q;
  logic [1:0]               fwd_q;
  logic [DATA_WIDTH-1:0]    result_a_q, result_b_q;

  logic                     accept, eng_start, eng_done;
  logic [F3_WIDTH-1:0]      eng_f3;
  logic [DATA_WIDTH-1:0]    eng_a, eng_b, eng_result;

  md_engine #(
    .DATA_WIDTH (DATA_WIDTH),
    .MUL_LAT    (MUL_LAT),
    .F3_WIDTH   (F3_WIDTH)
  ) u_engine (
    .clk      (clk),
    .rst      (rst),
    .kill_i   (flush),
    .start_i  (eng_start),
    .f3_i     (eng_f3),
    .a_i      (eng_a),
    .b_i      (eng_b),
    .done_o   (eng_done),
    .result_o (eng_result)
  );

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    eng_start = 1'b0;
    eng_f3    = f3_A;
    eng_a     = opa_A;
    eng_b     = opb_A;
    case (state_q)
      ST_IDLE: begin
        if (req_A || req_B) begin
          accept    = 1'b1;
          eng_start = 1'b1;
          if (req_A) begin
            state_d = ST_RUN_A;
          end else begin
            state_d = ST_RUN_B;
            eng_f3  = f3_B;
            eng_a   = opa_B;
            eng_b   = opb_B;
          end
        end
      end
      ST_RUN_A: begin
        // Lane B launches in the cycle A completes; forwarding is only reachable here,
        // so a lone lane B never sees fwd_B.
        if (eng_done) begin
          if (req_b_q) begin
            state_d   = ST_RUN_B;
            eng_start = 1'b1;
            eng_f3    = f3_b_q;
            eng_a     = fwd_q[FWD_OPA] ? eng_result : opa_b_q;
            eng_b     = fwd_q[FWD_OPB] ? eng_result : opb_b_q;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN_B: begin
        if (eng_done) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d   = ST_IDLE;
      accept    = 1'b0;
      eng_start = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_b_q    <= 1'b0;
      f3_b_q     <= '0;
      opa_b_q    <= '0;
      opb_b_q    <= '0;
      fwd_q      <= '0;
      result_a_q <= '0;
      result_b_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_b_q <= req_B;
        f3_b_q  <= f3_B;
        opa_b_q <= opa_B;
        opb_b_q <= opb_B;
        fwd_q   <= fwd_B;
      end
      if (eng_done && !flush) begin
        if (state_q == ST_RUN_A) result_a_q <= eng_result;
        if (state_q == ST_RUN_B) result_b_q <= eng_result;
      end
    end
  end

  assign done     = (state_q == ST_DONE) & ~flush;
  assign stall    = (req_A | req_B) & ~done & ~rst;
  assign busy     = (state_q != ST_IDLE);
  assign result_A = result_a_q;
  assign result_B = result_b_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Scoreboard bench for md_scheduler: directed RV32M cases plus random bundles
// checked against a plain-arithmetic reference model.
module tb_md_scheduler;
  import md_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic        req_A = 1'b0, req_B = 1'b0;
  logic [2:0]  f3_A = '0, f3_B = '0;
  logic [31:0] opa_A = '0, opb_A = '0, opa_B = '0, opb_B = '0;
  logic [1:0]  fwd_B = '0;
  logic        stall, done, busy;
  logic [31:0] result_A, result_B;

  md_scheduler #(.DATA_WIDTH(32), .MUL_LAT(2), .F3_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_A(req_A), .f3_A(f3_A), .opa_A(opa_A), .opb_A(opb_A),
    .req_B(req_B), .f3_B(f3_B), .opa_B(opa_B), .opb_B(opb_B),
    .fwd_B(fwd_B), .stall(stall), .done(done),
    .result_A(result_A), .result_B(result_B), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] ra;
    logic [31:0] rb;
    int          dcyc;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0, miscompares = 0;
  logic [31:0] last_a = '0, last_b = '0;
  bit          active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sbv;
    if (!f3[2]) begin
      ea = ((f3 == F3_MULH) || (f3 == F3_MULHSU)) ? {{32{a[31]}}, a} : {32'b0, a};
      eb = (f3 == F3_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ea * eb;
      return (f3 == F3_MUL) ? p[31:0] : p[63:32];
    end
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : a;
    if (!f3[0]) begin
      sa  = a;
      sbv = b;
      return f3[1] ? 32'(sa % sbv) : 32'(sa / sbv);
    end
    return f3[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 2;
    if (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  task automatic issue(input bit ra, input logic [2:0] fa, input logic [31:0] aa, input logic [31:0] ba,
                       input bit rb, input logic [2:0] fb, input logic [31:0] ab, input logic [31:0] bb,
                       input logic [1:0] fwd);
    exp_t e;
    int lat;
    logic [31:0] xa, xb, oa, ob;
    @(posedge clk); #1;
    req_A = ra; f3_A = fa; opa_A = aa; opb_A = ba;
    req_B = rb; f3_B = fb; opa_B = ab; opb_B = bb; fwd_B = fwd;
    lat = 0; xa = last_a; xb = last_b;
    if (ra) begin
      xa  = ref_op(fa, aa, ba);
      lat += ref_lat(fa, aa, ba);
    end
    if (rb) begin
      oa  = (ra && fwd[0]) ? xa : ab;
      ob  = (ra && fwd[1]) ? xa : bb;
      xb  = ref_op(fb, oa, ob);
      lat += ref_lat(fb, oa, ob);
    end
    e.ra = xa; e.rb = xb; e.dcyc = cyc + 1 + lat;
    sb.push_back(e);
    last_a = xa; last_b = xb;
    active = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: no done pulse within 200 cycles (cycle %0d)", cyc);
      sb.delete();
    end
    @(posedge clk); #1;
    req_A = 1'b0; req_B = 1'b0; active = 1'b0;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever the DUT signals done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (active) check(done ? "stall_at_done" : "stall_while_busy", {31'b0, stall}, {31'b0, ~done});
      if (done) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.dcyc));
          check("result_A", result_A, e.ra);
          check("result_B", result_B, e.rb);
        end
      end
    end
  end

  initial begin
    bit ra, rb;
    int n_done;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_result_A", result_A, 32'd0);
    check("rst_result_B", result_B, 32'd0);
    rst = 1'b0;

    issue(1, F3_MUL,   32'd7,          32'hFFFF_FFFD, 0, F3_MUL, 0, 0, 2'b00);
    issue(1, F3_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, F3_MUL, 0, 0, 2'b00);
    issue(0, F3_MUL, 0, 0, 1, F3_DIV, 32'hFFFF_FFF9, 32'd2, 2'b00);
    issue(0, F3_MUL, 0, 0, 1, F3_REM, 32'hFFFF_FFF9, 32'd2, 2'b11);
    issue(1, F3_DIVU, 32'd5, 32'd0, 0, F3_MUL, 0, 0, 2'b00);
    issue(1, F3_REM,  32'd5, 32'd0, 0, F3_MUL, 0, 0, 2'b00);
    issue(1, F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, F3_MUL, 0, 0, 2'b00);
    issue(1, F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0, F3_MUL, 0, 0, 2'b00);
    issue(1, F3_MUL,  32'd6, 32'd7, 1, F3_DIVU, 32'd0, 32'd5, 2'b01);
    issue(1, F3_MULH, 32'hFFFF_FFFE, 32'd3, 1, F3_MULHSU, 32'hFFFF_FFFF, 32'd9, 2'b10);

    for (int i = 0; i < 40; i++) begin
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      if (!ra && !rb) ra = 1'b1;
      issue(ra, 3'($urandom_range(0, 7)), rnd_val(), rnd_val(),
            rb, 3'($urandom_range(0, 7)), rnd_val(), rnd_val(), 2'($urandom_range(0, 3)));
    end

    // Flush ten cycles into a long divide: no done pulse, results untouched.
    @(posedge clk); #1;
    req_A = 1'b1; f3_A = F3_DIV; opa_A = 32'hFFFF_FF9C; opb_A = 32'd7; req_B = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_A = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_stall", {31'b0, stall}, 32'd0);
    check("flush_result_A", result_A, last_a);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("flush_no_done", 32'(n_done), 32'd0);

    // Asynchronous reset in the middle of a bundle.
    @(posedge clk); #1;
    req_A = 1'b1; f3_A = F3_DIVU; opa_A = 32'd1000; opb_A = 32'd3;
    req_B = 1'b1; f3_B = F3_MUL; opa_B = 32'd2; opb_B = 32'd3; fwd_B = 2'b00;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_stall", {31'b0, stall}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_result_A", result_A, 32'd0);
    check("arst_result_B", result_B, 32'd0);
    @(posedge clk); #1;
    req_A = 1'b0; req_B = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_a = '0; last_b = '0;
    issue(1, F3_MULHU, 32'h0001_0000, 32'h0003_0000, 1, F3_REMU, 32'd17, 32'd5, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
